// File: rtl/img_capture_pkg.sv
// Shared types and constants for the image frame capture block.
package img_capture_pkg;

  localparam int WORD_W      = 16;
  localparam int DEF_PIXEL_W = 12;

  localparam logic [11:0] DEF_HIGHLIGHT_THR = 12'hFF0;
  localparam logic [11:0] DEF_SHADOW_THR    = 12'h00F;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_IDLE  = 3'd1,
    WAIT_START = 3'd2,
    CAPTURE    = 3'd3,
    DRAIN      = 3'd4
  } cap_state_t;

endpackage

// File: rtl/img_capture_fifo.sv
// Single-clock first-word-fall-through FIFO; pop_data shows the head word whenever non-empty.
module img_capture_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Forced to zero when empty so the output never shows stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/img_frame_capture.sv
// Captures one full sensor frame on command and streams zero-extended pixels through a FWFT FIFO.
// Optional highlight/shadow statistics are built when IMG_CAPTURE_STATS_EN is defined.
module img_frame_capture
  import img_capture_pkg::*;
#(
  parameter int                   PIXEL_W       = DEF_PIXEL_W,
  parameter int                   FIFO_DEPTH    = 16,
  parameter int                   MAX_PIXELS    = 2304*1296,
  parameter logic [PIXEL_W-1:0]   HIGHLIGHT_THR = PIXEL_W'(DEF_HIGHLIGHT_THR),
  parameter logic [PIXEL_W-1:0]   SHADOW_THR    = PIXEL_W'(DEF_SHADOW_THR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] img_d,
  input  logic               img_fv,
  input  logic               img_lv,
  input  logic               cmd_capture,
  output logic [15:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               pix_trunc,
  output logic [31:0]        pix_count,
  output logic [15:0]        line_count,
  output logic [17:0]        highlight_cnt,
  output logic [17:0]        shadow_cnt,
  output logic [2:0]         state_dbg
);

  logic [PIXEL_W-1:0]        img_d_q;
  logic                      fv_q, lv_q, fv_qq, lv_qq;
  cap_state_t                state, state_nxt;
  logic                      fifo_push, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                      arm, in_frame, pix_valid, at_max, line_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      img_d_q <= '0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      fv_qq   <= 1'b0;
      lv_qq   <= 1'b0;
    end else begin
      img_d_q <= img_d;
      fv_q    <= img_fv;
      lv_q    <= img_lv;
      fv_qq   <= fv_q;
      lv_qq   <= lv_q;
    end
  end

  // The frame-start cycle is still in WAIT_START, so it already counts as in-frame.
  assign arm       = (state == IDLE) && cmd_capture;
  assign in_frame  = fv_q && ((state == CAPTURE) || ((state == WAIT_START) && !fv_qq));
  assign pix_valid = in_frame && lv_q;
  assign line_rise = in_frame && lv_q && !lv_qq;
  assign at_max    = (pix_count == 32'(MAX_PIXELS));
  assign fifo_push = pix_valid && !at_max && !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:       if (cmd_capture)       state_nxt = WAIT_IDLE;
      WAIT_IDLE:  if (!fv_q)             state_nxt = WAIT_START;
      WAIT_START: if (fv_q && !fv_qq)    state_nxt = CAPTURE;
      CAPTURE:    if (!fv_q)             state_nxt = DRAIN;
      DRAIN: begin
        if (fifo_empty) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      pix_count  <= '0;
      line_count <= '0;
      overflow   <= 1'b0;
      pix_trunc  <= 1'b0;
    end else begin
      if (fifo_push && (pix_count != '1)) pix_count <= pix_count + 32'd1;
      if (line_rise && (line_count != '1)) line_count <= line_count + 16'd1;
      if (pix_valid && at_max)               pix_trunc <= 1'b1;
      else if (pix_valid && fifo_full)       overflow  <= 1'b1;
    end
  end

`ifdef IMG_CAPTURE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      highlight_cnt <= '0;
      shadow_cnt    <= '0;
    end else if (fifo_push) begin
      if ((img_d_q >= HIGHLIGHT_THR) && (highlight_cnt != '1)) highlight_cnt <= highlight_cnt + 18'd1;
      if ((img_d_q <= SHADOW_THR) && (shadow_cnt != '1))       shadow_cnt    <= shadow_cnt + 18'd1;
    end
  end
`else
  logic unused_thr;
  assign unused_thr    = ^{HIGHLIGHT_THR, SHADOW_THR};
  assign highlight_cnt = '0;
  assign shadow_cnt    = '0;
`endif

  img_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (WORD_W'(img_d_q)),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (state != IDLE) || (fifo_level != '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_img_frame_capture.sv
// Directed bench for img_frame_capture: ramp frames, mid-frame arm, overflow, truncation, stats.
module tb_img_frame_capture;

  localparam int MAX_PIX = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] img_d = '0;
  logic        img_fv = 1'b0;
  logic        img_lv = 1'b0;
  logic        cmd_capture = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, done, overflow, pix_trunc;
  logic [31:0] pix_count;
  logic [15:0] line_count;
  logic [17:0] highlight_cnt, shadow_cnt;
  logic [2:0]  state_dbg;

  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          done_base;

  img_frame_capture #(
    .PIXEL_W    (12),
    .FIFO_DEPTH (16),
    .MAX_PIXELS (MAX_PIX)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .img_d         (img_d),
    .img_fv        (img_fv),
    .img_lv        (img_lv),
    .cmd_capture   (cmd_capture),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .pix_trunc     (pix_trunc),
    .pix_count     (pix_count),
    .line_count    (line_count),
    .highlight_cnt (highlight_cnt),
    .shadow_cnt    (shadow_cnt),
    .state_dbg     (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted word is compared against the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("word_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
    if (done) done_cnt++;
  end

  // drivers
  task automatic drive(input logic fv, input logic lv, input logic [11:0] d);
    @(posedge clk);
    #1;
    img_fv = fv;
    img_lv = lv;
    img_d  = d;
  endtask

  task automatic arm_capture();
    cmd_capture = 1'b1;
    drive(1'b0, 1'b0, 12'h0);
    cmd_capture = 1'b0;
    drive(1'b0, 1'b0, 12'h0);
    drive(1'b0, 1'b0, 12'h0);
  endtask

  task automatic send_frame(input int lines, input int ppl, input int start, input int exp_limit);
    int k = 0;
    drive(1'b1, 1'b0, 12'h0);
    drive(1'b1, 1'b0, 12'h0);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        drive(1'b1, 1'b1, 12'(start + k));
        if (k < exp_limit) exp_q.push_back(16'(start + k));
        k++;
      end
      drive(1'b1, 1'b0, 12'h0);
      drive(1'b1, 1'b0, 12'h0);
    end
    drive(1'b0, 1'b0, 12'h0);
    drive(1'b0, 1'b0, 12'h0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && (done_cnt == done_base); i++) @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
    check({tag, "_exp_q_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pix_count", pix_count, 32'd0);
    check("rst_line_count", 32'(line_count), 32'd0);
    check("rst_flags", {30'd0, overflow, pix_trunc}, 32'd0);
    check("rst_stats", 32'(highlight_cnt) + 32'(shadow_cnt), 32'd0);
    rst = 1'b0;

    // reset in the middle of a capture
    out_ready = 1'b0;
    done_base = done_cnt;
    arm_capture();
    drive(1'b1, 1'b0, 12'h0);
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b1, 12'(i));
    drive(1'b1, 1'b0, 12'h0);
    drive(1'b1, 1'b0, 12'h0);
    @(negedge clk);
    check("t1_pre_pix_count", pix_count, 32'd5);
    check("t1_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_pix_count", pix_count, 32'd0);
    check("t1_line_count", 32'(line_count), 32'd0);
    check("t1_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 12'h0);
    repeat (5) drive(1'b0, 1'b0, 12'h0);
    @(negedge clk);
    check("t1_no_done", 32'(done_cnt - done_base), 32'd0);

    // 4 lines x 8 px ramp
    out_ready = 1'b1;
    done_base = done_cnt;
    arm_capture();
    send_frame(4, 8, 0, 32);
    wait_done("t2");
    check("t2_pix_count", pix_count, 32'd32);
    check("t2_line_count", 32'(line_count), 32'd4);

    // arm in the middle of a frame: that frame is skipped
    done_base = done_cnt;
    drive(1'b1, 1'b0, 12'h0);
    drive(1'b1, 1'b1, 12'd99);
    cmd_capture = 1'b1;
    drive(1'b1, 1'b1, 12'd100);
    cmd_capture = 1'b0;
    for (int i = 101; i < 106; i++) drive(1'b1, 1'b1, 12'(i));
    drive(1'b1, 1'b0, 12'h0);
    drive(1'b0, 1'b0, 12'h0);
    drive(1'b0, 1'b0, 12'h0);
    @(negedge clk);
    check("t3_waiting_pix_count", pix_count, 32'd0);
    send_frame(2, 8, 64, 16);
    wait_done("t3");
    check("t3_pix_count", pix_count, 32'd16);
    check("t3_line_count", 32'(line_count), 32'd2);

    // consumer stalled during a 20 px line: only 16 words fit
    out_ready = 1'b0;
    done_base = done_cnt;
    arm_capture();
    send_frame(1, 20, 200, 16);
    @(negedge clk);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_pix_count", pix_count, 32'd16);
    check("t4_head_word", 32'(out_data), 32'd200);
    check("t4_busy_held", 32'(busy), 32'd1);
    check("t4_no_early_done", 32'(done_cnt - done_base), 32'd0);
    out_ready = 1'b1;
    wait_done("t4");

    // truncation at MAX_PIX = 40 with a 48 px frame
    done_base = done_cnt;
    arm_capture();
    check("t5_overflow_cleared", 32'(overflow), 32'd0);
    send_frame(6, 8, 300, MAX_PIX);
    wait_done("t5");
    check("t5_pix_trunc", 32'(pix_trunc), 32'd1);
    check("t5_overflow", 32'(overflow), 32'd0);
    check("t5_pix_count", pix_count, 32'(MAX_PIX));
    check("t5_line_count", 32'(line_count), 32'd6);

    // threshold statistics
    done_base = done_cnt;
    arm_capture();
    drive(1'b1, 1'b0, 12'h0);
    foreach (exp_stat_px[i]) begin
      drive(1'b1, 1'b1, exp_stat_px[i]);
      exp_q.push_back(16'(exp_stat_px[i]));
    end
    drive(1'b1, 1'b0, 12'h0);
    drive(1'b0, 1'b0, 12'h0);
    wait_done("t6");
    check("t6_pix_trunc_cleared", 32'(pix_trunc), 32'd0);
    check("t6_pix_count", pix_count, 32'd5);
`ifdef IMG_CAPTURE_STATS_EN
    check("t6_shadow_cnt", 32'(shadow_cnt), 32'd2);
    check("t6_highlight_cnt", 32'(highlight_cnt), 32'd2);
`else
    check("t6_shadow_cnt", 32'(shadow_cnt), 32'd0);
    check("t6_highlight_cnt", 32'(highlight_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  logic [11:0] exp_stat_px [5] = '{12'h000, 12'h00F, 12'h010, 12'hFF0, 12'hFFF};

endmodule
